uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Transmit-side buffer for the UART link. It accepts bytes from the host/decoder side and presents them, first-word-fall-through, to the `Transmitter` through `i_tx_data`/`i_fifo_empty`. It pops one entry per completed frame, so the host can queue bursts without waiting on the serial line.

## Interface
- `SIZE_DATA`, default 8: data width; must match `Transmitter.SIZE_DATA`.
- `DEPTH`, default 16: number of entries; power of two, ≥ 2.
- `ADDR_W`, default `$clog2(DEPTH)`: derived; must not be overridden.

- `i_clk`: in, 1. Single system clock, same as baud_generator/Transmitter.
- `i_rst`: in, 1. Reset; synchronous, active-high.
- `i_wr_en`: in, 1. Host write strobe; one entry per asserted cycle.
- `i_wr_data`: in, SIZE_DATA. Byte to enqueue.
- `o_full`: out, 1. No free entry.
- `i_tx_done`: in, 1. Pop strobe; wired to `Transmitter.o_tx_done`, single-cycle pulse.
- `o_tx_data`: out, SIZE_DATA. Head entry; feeds `Transmitter.i_tx_data`.
- `o_fifo_empty`: out, 1. No valid entry; feeds `Transmitter.i_fifo_empty`.
- `o_count`: out, ADDR_W+1. Current occupancy, 0..DEPTH.
- `i_clr_err`: in, 1. Clears sticky error flags; only present with the macro.
- `o_overflow`: out, 1. Sticky flag; only present with the macro.
- `o_underflow`: out, 1. Sticky flag; only present with the macro.

## Operation
- Storage: `DEPTH` × `SIZE_DATA` register array. Contents are not reset.
- Pointers: `wr_ptr` and `rd_ptr`, each ADDR_W+1 bits.
  - The index is the low ADDR_W bits; the MSB is the wrap bit.
  - Both increment modulo 2^(ADDR_W+1).
- Flags:
  - Empty when `wr_ptr == rd_ptr`.
  - Full when the low bits are equal and the MSBs differ.
  - `o_count = wr_ptr - rd_ptr`, computed mod 2^(ADDR_W+1).
- Write accept: `wr_acc = i_wr_en & (~o_full | rd_acc)`.
- Pop accept: `rd_acc = i_tx_done & ~o_fifo_empty`.
- Write + pop in the same cycle:
  - Not full, not empty: both happen; count unchanged.
  - Full: both accepted; the freed slot is rewritten; stays full.
  - Empty: write accepted, pop ignored; count becomes 1.
- Write while full without pop: dropped; storage and pointers unchanged.
- Pop while empty: ignored.
- `o_tx_data`:
  - Combinational read of `mem[rd_ptr[ADDR_W-1:0]]`, gated to 0 while empty.
  - Held stable from the cycle the entry becomes head until the cycle after its pop.
- No state machine beyond the pointer pair. Flags derive only from registered pointers, with no combinational path from inputs to flags.

## Timing
- Reset values (cycle after `i_rst` sampled high):
  - Pointers 0, `o_count` = 0.
  - `o_fifo_empty` = 1, `o_full` = 0, `o_tx_data` = 0.
  - `o_overflow` = 0, `o_underflow` = 0.
- Reset mid-burst discards all queued entries. `i_wr_en` and `i_tx_done` in the reset cycle are ignored.
- Write latency: a byte written at edge N is on `o_tx_data` with `o_fifo_empty` = 0 after edge N. It is visible to the Transmitter in cycle N+1.
- Pop latency: after the edge that samples `i_tx_done`, the next entry (or empty) appears.
- `o_full` asserts after the edge that writes the DEPTH-th entry. It deasserts after the first pop edge.
- Full throughput: one write and one pop per cycle.

## Configuration
- Macro: `UART_TX_FIFO_ERR_EN`.
- Defined:
  - Ports `i_clr_err`, `o_overflow` and `o_underflow` exist.
  - `o_overflow` sets on a dropped write (`i_wr_en` & full & no pop).
  - `o_underflow` sets on `i_tx_done` while empty.
  - Both flags hold until `i_clr_err` or `i_rst`.
  - If set and clear happen in the same cycle, set wins.
- Undefined:
  - These three ports and their logic are absent.
  - Dropped writes and empty pops are silently ignored.
  - All other behaviour is identical.

## Test plan
- Reset, then write 0x29 → next cycle `o_fifo_empty` = 0, `o_tx_data` = 0x29, `o_count` = 1. One `i_tx_done` pulse → empty = 1, `o_tx_data` = 0.
- Write 0x00..0x0F (DEPTH = 16) → `o_full` = 1, `o_count` = 16. Write 0xAA → dropped, `o_overflow` = 1 (macro on). Pop 16 times → data 0x00..0x0F in order.
- Full FIFO, write 0x55 and pop in the same cycle → head advances to 0x01, `o_full` stays 1. After 15 more pops, the last entry read is 0x55.
- Empty FIFO, write 0x77 and `i_tx_done` in the same cycle → `o_count` = 1, head = 0x77, `o_underflow` stays 0. `i_tx_done` alone while empty → `o_underflow` = 1; `i_clr_err` → 0.
- 40 interleaved write/pop cycles crossing the pointer wrap → data order preserved, `o_count` matches the scoreboard every cycle.
- End-to-end with baud_generator (325), Transmitter and Receiver; queue 0x29, 0xA5, 0x00 → `Receiver.o_rx_data` shows the same three bytes in order. FIFO ends empty.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - first-word-fall-through transmit FIFO feeding the UART Transmitter
// Optional sticky overflow/underflow flags enabled by defining UART_TX_FIFO_ERR_EN.
module uart_tx_fifo #(
  parameter int SIZE_DATA = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_en,
  input  logic [SIZE_DATA-1:0] i_wr_data,
  output logic                 o_full,
  input  logic                 i_tx_done,
  output logic [SIZE_DATA-1:0] o_tx_data,
  output logic                 o_fifo_empty,
  output logic [ADDR_W:0]      o_count
`ifdef UART_TX_FIFO_ERR_EN
  ,
  input  logic                 i_clr_err,
  output logic                 o_overflow,
  output logic                 o_underflow
`endif
);

  logic [SIZE_DATA-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]      wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]      rd_ptr_q, rd_ptr_d;
  logic                 wr_acc;
  logic                 rd_acc;

  // Flags come only from registered pointers; the MSB is the wrap bit.
  assign o_fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full       = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                        (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
  assign o_count      = wr_ptr_q - rd_ptr_q;
  assign o_tx_data    = o_fifo_empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];

  assign rd_acc = i_tx_done & ~o_fifo_empty;
  assign wr_acc = i_wr_en & (~o_full | rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (wr_acc && !i_rst) mem_q[wr_ptr_q[ADDR_W-1:0]] <= i_wr_data;
  end

`ifdef UART_TX_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;
  logic ovf_set, unf_set;

  // A pop that coincides with a write into an empty FIFO is not an underflow.
  assign ovf_set = i_wr_en & o_full & ~rd_acc;
  assign unf_set = i_tx_done & o_fifo_empty & ~i_wr_en;

  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (i_clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (ovf_set) overflow_d  = 1'b1;
    if (unf_set) underflow_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;
  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_wr_en = 1'b0;
  logic [7:0] i_wr_data = 8'h00;
  logic       i_tx_done = 1'b0;
  logic       i_clr_err = 1'b0;
  logic       o_full;
  logic [7:0] o_tx_data;
  logic       o_fifo_empty;
  logic [4:0] o_count;
`ifdef UART_TX_FIFO_ERR_EN
  logic       o_overflow;
  logic       o_underflow;
`endif

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(.SIZE_DATA(8), .DEPTH(16)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_wr_en(i_wr_en),
    .i_wr_data(i_wr_data),
    .o_full(o_full),
    .i_tx_done(i_tx_done),
    .o_tx_data(o_tx_data),
    .o_fifo_empty(o_fifo_empty),
    .o_count(o_count)
`ifdef UART_TX_FIFO_ERR_EN
    ,
    .i_clr_err(i_clr_err),
    .o_overflow(o_overflow),
    .o_underflow(o_underflow)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic cyc(input logic wr, input logic [7:0] d, input logic pop, input logic clr);
    i_wr_en   = wr;
    i_wr_data = d;
    i_tx_done = pop;
    i_clr_err = clr;
    @(posedge i_clk);
    #1;
    i_wr_en   = 1'b0;
    i_tx_done = 1'b0;
    i_clr_err = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    cyc(1'b1, 8'hEE, 1'b1, 1'b0);
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", o_count); end
    checks++; if (o_fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", o_fifo_empty); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", o_full); end
    checks++; if (o_tx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", o_tx_data); end
`ifdef UART_TX_FIFO_ERR_EN
    checks++; if (o_overflow !== 1'b0 || o_underflow !== 1'b0) begin errors++; $display("FAIL reset_err got %b%b want 00", o_overflow, o_underflow); end
`endif
  endtask

  task automatic test_single();
    cyc(1'b1, 8'h29, 1'b0, 1'b0);
    checks++; if (o_fifo_empty !== 1'b0) begin errors++; $display("FAIL single_empty got %b want 0", o_fifo_empty); end
    checks++; if (o_tx_data !== 8'h29) begin errors++; $display("FAIL single_data got %h want 29", o_tx_data); end
    checks++; if (o_count !== 5'd1) begin errors++; $display("FAIL single_count got %0d want 1", o_count); end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (o_fifo_empty !== 1'b1) begin errors++; $display("FAIL single_pop_empty got %b want 1", o_fifo_empty); end
    checks++; if (o_tx_data !== 8'h00) begin errors++; $display("FAIL single_pop_data got %h want 00", o_tx_data); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 16; i++) begin
      checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL fill_early_full at %0d got %b want 0", i, o_full); end
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
    end
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", o_full); end
    checks++; if (o_count !== 5'd16) begin errors++; $display("FAIL fill_count got %0d want 16", o_count); end
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    checks++; if (o_count !== 5'd16 || o_tx_data !== 8'h00) begin errors++; $display("FAIL drop_write got count %0d head %h want 16 00", o_count, o_tx_data); end
`ifdef UART_TX_FIFO_ERR_EN
    checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got %b want 1", o_overflow); end
`endif
    for (int i = 0; i < 16; i++) begin
      checks++; if (o_tx_data !== 8'(i)) begin errors++; $display("FAIL drain_order at %0d got %h want %h", i, o_tx_data, 8'(i)); end
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      if (i == 0) begin
        checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL full_release got %b want 0", o_full); end
      end
    end
    checks++; if (o_fifo_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", o_fifo_empty); end
`ifdef UART_TX_FIFO_ERR_EN
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL overflow_clr got %b want 0", o_overflow); end
`endif
  endtask

  task automatic test_full_wr_pop();
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    checks++; if (o_tx_data !== 8'h01) begin errors++; $display("FAIL fullwp_head got %h want 01", o_tx_data); end
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL fullwp_full got %b want 1", o_full); end
`ifdef UART_TX_FIFO_ERR_EN
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL fullwp_ovf got %b want 0", o_overflow); end
`endif
    for (int j = 1; j < 16; j++) begin
      checks++; if (o_tx_data !== 8'(j)) begin errors++; $display("FAIL fullwp_order at %0d got %h want %h", j, o_tx_data, 8'(j)); end
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (o_tx_data !== 8'h55 || o_count !== 5'd1) begin errors++; $display("FAIL fullwp_last got %h cnt %0d want 55 1", o_tx_data, o_count); end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (o_fifo_empty !== 1'b1) begin errors++; $display("FAIL fullwp_empty got %b want 1", o_fifo_empty); end
  endtask

  task automatic test_empty_wr_pop();
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    checks++; if (o_count !== 5'd1 || o_tx_data !== 8'h77) begin errors++; $display("FAIL emptywp got cnt %0d head %h want 1 77", o_count, o_tx_data); end
`ifdef UART_TX_FIFO_ERR_EN
    checks++; if (o_underflow !== 1'b0) begin errors++; $display("FAIL emptywp_unf got %b want 0", o_underflow); end
`endif
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (o_fifo_empty !== 1'b1 || o_count !== 5'd0) begin errors++; $display("FAIL empty_pop got empty %b cnt %0d want 1 0", o_fifo_empty, o_count); end
`ifdef UART_TX_FIFO_ERR_EN
    checks++; if (o_underflow !== 1'b1) begin errors++; $display("FAIL underflow_set got %b want 1", o_underflow); end
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    checks++; if (o_underflow !== 1'b1) begin errors++; $display("FAIL underflow_setwins got %b want 1", o_underflow); end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (o_underflow !== 1'b0) begin errors++; $display("FAIL underflow_clr got %b want 0", o_underflow); end
`endif
  endtask

  task automatic test_interleave();
    logic [7:0] q[$];
    logic       wr, pop, rd_acc, wr_acc;
    logic [7:0] d;
    int         bad = 0;
    for (int k = 0; k < 40; k++) begin
      wr  = (k % 3) != 2;
      pop = (k % 2) == 1;
      d   = 8'(8'hC0 + k);
      rd_acc = pop && (q.size() != 0);
      wr_acc = wr && ((q.size() != 16) || rd_acc);
      cyc(wr, d, pop, 1'b0);
      if (rd_acc) void'(q.pop_front());
      if (wr_acc) q.push_back(d);
      checks++;
      if (o_count !== 5'(q.size()) || (q.size() != 0 && o_tx_data !== q[0])) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL interleave cyc %0d got cnt %0d head %h want cnt %0d", k, o_count, o_tx_data, q.size());
      end
    end
    while (q.size() != 0) begin
      checks++; if (o_tx_data !== q[0]) begin errors++; $display("FAIL interleave_drain got %h want %h", o_tx_data, q[0]); end
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      void'(q.pop_front());
    end
    checks++; if (o_fifo_empty !== 1'b1) begin errors++; $display("FAIL interleave_empty got %b want 1", o_fifo_empty); end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 1'b0, 1'b0);
    do_reset();
    checks++; if (o_count !== 5'd0 || o_fifo_empty !== 1'b1 || o_tx_data !== 8'h00) begin errors++; $display("FAIL reset_mid got cnt %0d empty %b data %h want 0 1 00", o_count, o_fifo_empty, o_tx_data); end
    cyc(1'b1, 8'h44, 1'b0, 1'b0);
    checks++; if (o_tx_data !== 8'h44 || o_count !== 5'd1) begin errors++; $display("FAIL reset_mid_write got %h cnt %0d want 44 1", o_tx_data, o_count); end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    @(negedge i_clk);
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_wr_pop();
    test_empty_wr_pop();
    test_interleave();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
